// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if
// Bundle of the N-to-1 round-robin stream mux handshake and data signals.
//
// Signals:
//   in_valid  [NUM_CH]            per-channel valid, bit i = channel i
//   in_data   [NUM_CH*BUS_WIDTH]  packed data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   in_ready  [NUM_CH]            per-channel ready, one-hot or zero
//   out_valid                     output register holds a beat
//   out_data  [BUS_WIDTH]         registered output data
//   out_ch    [CH_W]              channel that sourced out_data
//   out_ready                     downstream accept
//   in_last / out_last            packet delimiters, only with STREAM_MUX_LOCK_EN
//
// Modports: master = traffic source/sink side, slave = the mux.
// Optional feature macro: STREAM_MUX_LOCK_EN.
// ---------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = $clog2(NUM_CH)
);

  logic [NUM_CH-1:0]           in_valid;
  logic [NUM_CH*BUS_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]           in_ready;
  logic                        out_valid;
  logic [BUS_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]             out_ch;
  logic                        out_ready;

`ifdef STREAM_MUX_LOCK_EN
  logic [NUM_CH-1:0]           in_last;
  logic                        out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
`endif

endinterface

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// Round-robin multiplexer of NUM_CH valid/ready input streams onto one
// registered output stream. The grant is searched from the channel after the
// last winner (ptr) with wrap-around; the output register sustains one beat
// per clock when downstream drains and a new beat loads in the same cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    stream_mux_rr_if.slave (inputs in_valid/in_data/out_ready,
//          outputs in_ready/out_valid/out_data/out_ch)
//
// Optional feature macro: STREAM_MUX_LOCK_EN
//   Adds in_last/out_last. A beat with in_last==0 locks arbitration onto its
//   channel until that channel delivers a beat with in_last==1.
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            reset,
  stream_mux_rr_if.slave  bus
);

  // ptr resets to the last channel so channel 0 is searched first
  localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

  // Output register and arbitration pointer
  logic                 out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]      out_ch_q,    out_ch_d;
  logic [CH_W-1:0]      ptr_q,       ptr_d;

  // Grant datapath
  logic                 can_load;
  logic                 grant_found;
  logic [CH_W-1:0]      grant_idx;
  logic [BUS_WIDTH-1:0] grant_data;
  logic                 xfer;
  logic [NUM_CH-1:0]    in_ready_c;
  int unsigned          cand;
  logic [CH_W-1:0]      cand_idx;

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e          state_q,   state_d;
  logic [CH_W-1:0]      lock_ch_q, lock_ch_d;
  logic                 out_last_q, out_last_d;
`endif

  // Output register can take a new beat when empty or being drained
  assign can_load = !out_valid_q || bus.out_ready;

  // Rotating priority search starting at ptr+1; a held lock overrides it
  always_comb begin : grant_search
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_idx = CH_W'(cand);
      if (!grant_found && bus.in_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    if (state_q == ST_LOCKED) begin
      grant_found = bus.in_valid[lock_ch_q];
      grant_idx   = lock_ch_q;
    end
`endif
  end

  // Select the granted channel's data slice
  always_comb begin : data_select
    grant_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == grant_idx) begin
        grant_data = bus.in_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // No transfer is allowed while reset is asserted
  assign xfer = can_load && grant_found && !reset;

  // One-hot ready for the granted channel only
  always_comb begin : ready_decode
    in_ready_c = '0;
    if (xfer) begin
      in_ready_c[grant_idx] = 1'b1;
    end
  end

  // Output register and pointer next-state
  always_comb begin : out_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      ptr_d       = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer state
  always_ff @(posedge clk or posedge reset) begin : out_regs
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // Packet lock FSM: non-last beat locks, last beat from the locked channel frees
  always_comb begin : lock_next
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (xfer) begin
      out_last_d = bus.in_last[grant_idx];
      case (state_q)
        ST_FREE: begin
          if (!bus.in_last[grant_idx]) begin
            state_d   = ST_LOCKED;
            lock_ch_d = grant_idx;
          end
        end
        ST_LOCKED: begin
          if (bus.in_last[grant_idx]) begin
            state_d = ST_FREE;
          end
        end
        default: state_d = ST_FREE;
      endcase
    end
  end

  // Lock state and registered out_last
  always_ff @(posedge clk or posedge reset) begin : lock_regs
    if (reset) begin
      state_q    <= ST_FREE;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign bus.out_last = out_last_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
// Scoreboard bench for stream_mux_rr (NUM_CH=4, BUS_WIDTH=8). A driver issues
// one cycle of stimulus at a time and predicts grants from the round-robin
// rules; predicted beats go into a queue that a separate monitor pops when
// the DUT's output handshake completes. Build with +define+STREAM_MUX_LOCK_EN
// to exercise packet locking.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int unsigned BW          = 8;
  localparam int unsigned NCH         = 4;
  localparam int unsigned CHW         = 2;
  localparam int unsigned RAND_CYCLES = 10000;

  typedef struct {
    int ch;
    int data;
    int last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.BUS_WIDTH(BW), .NUM_CH(NCH), .CH_W(CHW)) bus ();

  stream_mux_rr #(.BUS_WIDTH(BW), .NUM_CH(NCH), .CH_W(CHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  bit    done = 1'b0;

  // Reference state: last winner, output occupancy, packet lock
  int m_ptr;
  int m_ov;
  int m_locked;
  int m_lock_ch;
  int seq[NCH];

  logic [NCH*BW-1:0] r_d;
  logic [NCH-1:0]    r_v;
  logic [NCH-1:0]    r_l;
  logic              r_rdy;
  int                g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = NCH - 1;
    m_ov      = 0;
    m_locked  = 0;
    m_lock_ch = 0;
    exp_q.delete();
  endtask

  // First valid channel after the last winner, or the locked channel only
  function automatic int model_grant(input logic [NCH-1:0] v);
    int c;
    if (m_locked != 0) begin
      return v[m_lock_ch] ? m_lock_ch : -1;
    end
    for (int k = 1; k <= NCH; k++) begin
      c = (m_ptr + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Drive one cycle, check ready/valid against the model, predict the beat
  task automatic do_cycle(input logic [NCH-1:0] v, input logic [NCH*BW-1:0] d,
                          input logic [NCH-1:0] l, input logic rdy, output int gnt);
    logic [NCH-1:0] exp_rdy;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last   = l;
`endif
    bus.out_ready = rdy;
    #1;
    gnt = model_grant(v);
    if (m_ov != 0 && !rdy) gnt = -1;
    exp_rdy = '0;
    if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, m_ov);
    if (gnt >= 0) begin
      exp_q.push_back('{gnt, int'(d[gnt*BW +: BW]), int'(l[gnt])});
      m_ptr = gnt;
      m_ov  = 1;
`ifdef STREAM_MUX_LOCK_EN
      if (m_locked == 0 && !l[gnt]) begin
        m_locked  = 1;
        m_lock_ch = gnt;
      end else if (m_locked != 0 && l[gnt]) begin
        m_locked = 0;
      end
`endif
    end else if (rdy) begin
      m_ov = 0;
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    bus.in_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_async_out_valid", bus.out_valid, 0);
    chk("rst_async_in_ready", bus.in_ready, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pop and compare on every completed output handshake
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (done) break;
      chk("in_ready_onehot0", $onehot0(bus.in_ready), 1);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got ch %0d data %0h, no beat expected",
                   bus.out_ch, bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_out_ch", bus.out_ch, mon_e.ch);
          chk("sb_out_data", bus.out_data, mon_e.data);
`ifdef STREAM_MUX_LOCK_EN
          chk("sb_out_last", bus.out_last, mon_e.last);
`endif
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last   = '0;
`endif
    model_reset();
    for (int i = 0; i < NCH; i++) seq[i] = 0;

    // Reset values, with every channel requesting
    repeat (2) @(negedge clk);
    bus.in_valid = '1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    bus.in_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // All channels valid, out_ready high: 0,1,2,3,0 back to back
    r_d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 6; k++) begin
      do_cycle(4'b1111, r_d, 4'b1111, 1'b1, g);
      if (k >= 1) begin
        chk("rr_seq_valid", bus.out_valid, 1);
        chk("rr_seq_ch", bus.out_ch, (k - 1) % 4);
        chk("rr_seq_data", bus.out_data, 8'hA0 + ((k - 1) % 4));
      end
    end
    repeat (2) do_cycle(4'b0000, '0, 4'b1111, 1'b1, g);

    // Backpressure: ch2 beat held for 3 cycles, then replaced without a bubble
    r_d = {8'h00, 8'h5C, 8'h00, 8'h00};
    do_cycle(4'b0100, r_d, 4'b1111, 1'b0, g);
    for (int k = 0; k < 3; k++) begin
      do_cycle(4'b0100, r_d, 4'b1111, 1'b0, g);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_data", bus.out_data, 8'h5C);
      chk("hold_out_ch", bus.out_ch, 2);
      chk("hold_in_ready", bus.in_ready, 4'b0000);
    end
    r_d = {8'h00, 8'h5D, 8'h00, 8'h00};
    do_cycle(4'b0100, r_d, 4'b1111, 1'b1, g);
    chk("drain_reload_ready", bus.in_ready, 4'b0100);
    do_cycle(4'b0000, '0, 4'b1111, 1'b1, g);
    chk("no_bubble_valid", bus.out_valid, 1);
    chk("no_bubble_data", bus.out_data, 8'h5D);
    do_cycle(4'b0000, '0, 4'b1111, 1'b1, g);

    // Reset mid-cycle while a beat is held, then wrap-around from ptr=3
    do_cycle(4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 4'b1111, 1'b0, g);
    do_cycle(4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 4'b1111, 1'b0, g);
    chk("pre_rst_valid", bus.out_valid, 1);
    pulse_reset();
    r_d = {8'h00, 8'h22, 8'h00, 8'h20};
    do_cycle(4'b0101, r_d, 4'b1111, 1'b1, g);
    chk("wrap_grant0", bus.in_ready, 4'b0001);
    do_cycle(4'b0101, r_d, 4'b1111, 1'b1, g);
    chk("wrap_grant1", bus.in_ready, 4'b0100);
    do_cycle(4'b0101, r_d, 4'b1111, 1'b1, g);
    chk("wrap_grant2", bus.in_ready, 4'b0001);
    repeat (2) do_cycle(4'b0000, '0, 4'b1111, 1'b1, g);

`ifdef STREAM_MUX_LOCK_EN
    // ch1 3-beat packet while ch0 and ch3 request; ch3 wins afterwards
    do_cycle(4'b0001, {8'h00, 8'h00, 8'h00, 8'h30}, 4'b1111, 1'b1, g);
    for (int k = 0; k < 3; k++) begin
      r_d = {8'hD3, 8'h00, 8'(8'hB1 + k), 8'hD0};
      r_l = (k == 2) ? 4'b1111 : 4'b1101;
      do_cycle(4'b1011, r_d, r_l, 1'b1, g);
      chk("lock_grant", bus.in_ready, 4'b0010);
      if (k >= 1) begin
        chk("lock_out_ch", bus.out_ch, 1);
        chk("lock_out_last", bus.out_last, 0);
      end
    end
    do_cycle(4'b1001, {8'hD3, 8'h00, 8'h00, 8'hD0}, 4'b1111, 1'b1, g);
    chk("unlock_grant", bus.in_ready, 4'b1000);
    chk("pkt_end_ch", bus.out_ch, 1);
    chk("pkt_end_last", bus.out_last, 1);
    repeat (2) do_cycle(4'b0000, '0, 4'b1111, 1'b1, g);
`endif

    // Randomized traffic with per-channel sequence-numbered data
    for (int n = 0; n < RAND_CYCLES; n++) begin
      for (int i = 0; i < NCH; i++) begin
        r_v[i] = ($urandom_range(0, 9) < 6);
        r_l[i] = ($urandom_range(0, 2) == 0);
        r_d[i*BW +: BW] = 8'((i << 6) | (seq[i] & 63));
      end
      r_rdy = ($urandom_range(0, 9) < 7);
      do_cycle(r_v, r_d, r_l, r_rdy, g);
      if (g >= 0) seq[g]++;
    end
    repeat (4) do_cycle(4'b0000, '0, 4'b1111, 1'b1, g);
    chk("sb_empty", exp_q.size(), 0);

    done = 1'b1;
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter BUS_WIDTH, default 8, sets the data width per channel in bits.
REQ-002 Parameter NUM_CH, default 4, sets the number of input channels; legal range 2..16.
REQ-003 Parameter CH_W, default $clog2(NUM_CH), sets the width of the channel index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  NUM_CH  per-channel valid; bit i belongs to channel i.
REQ-007 in_data  input  NUM_CH*BUS_WIDTH  packed data; channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-008 in_ready  output  NUM_CH  per-channel ready; at most one bit is set in any cycle.
REQ-009 out_valid  output  1  output register holds a beat.
REQ-010 out_data  output  BUS_WIDTH  registered output data.
REQ-011 out_ch  output  CH_W  index of the channel that sourced out_data.
REQ-012 out_ready  input  1  downstream accepts the beat when out_valid && out_ready.

Function
REQ-013 The output register shall accept a beat ("can_load") when out_valid==0 or out_ready==1.
REQ-014 Grant shall be computed combinationally as the first i with in_valid[i]==1, searching from (ptr+1) mod NUM_CH upward with wrap-around.
REQ-015 in_ready[g] shall be 1 only when can_load==1 and g is the granted channel; all other in_ready bits shall be 0.
REQ-016 On an input transfer (in_valid[g] && in_ready[g]), the block shall load out_data<=in_data[g], out_ch<=g and out_valid<=1 at the next edge, giving a latency of 1 cycle.
REQ-017 On an input transfer, ptr shall be set to g; otherwise ptr shall hold.
REQ-018 If out_valid && out_ready and no input transfer occurs, out_valid shall go to 0.
REQ-019 Simultaneous output drain and input transfer shall replace the beat with no bubble, sustaining 1 beat/clk.
REQ-020 While out_valid==1 and out_ready==0, out_data, out_ch and out_valid shall hold stable and all in_ready bits shall be 0.
REQ-021 With in_valid==0, no grant shall be issued and ptr shall hold.
REQ-022 in_ready shall not depend combinationally on out_data, and shall depend only on in_valid, ptr, lock state, out_valid and out_ready.

Reset
REQ-023 Asserting reset shall asynchronously clear out_valid=0, out_data=0, out_ch=0 and in_ready=0, and set ptr=NUM_CH-1 so that channel 0 has first priority; with STREAM_MUX_LOCK_EN it shall also clear locked=0 and out_last=0.
REQ-024 Asserting reset mid-packet or with a beat held shall discard that beat, and no transfer shall occur in a cycle where reset is high.

Configuration
REQ-025 Macro STREAM_MUX_LOCK_EN, when defined, shall add the ports in_last (input, NUM_CH) and out_last (output, 1), with out_last registered alongside out_data.
REQ-026 With STREAM_MUX_LOCK_EN, a transfer with in_last[g]==0 shall set locked=1 and lock_ch=g; while locked, only lock_ch shall be granted, regardless of the other channels' valid bits.
REQ-027 With STREAM_MUX_LOCK_EN, a transfer from lock_ch with in_last==1 shall clear locked, and round-robin shall resume from ptr=lock_ch.
REQ-028 Without STREAM_MUX_LOCK_EN, the in_last, out_last and lock logic shall be absent, and arbitration shall be per beat.

Verification (NUM_CH=4, BUS_WIDTH=8)
REQ-029 Reset release, all in_valid=4'b1111 with data 8'hA0..8'hA3, and out_ready=1 held -> out_ch sequence 0,1,2,3,0, one beat per clk, first out_valid one cycle after the first transfer.
REQ-030 Only ch2 valid with data 8'h5C and out_ready=0 for 3 cycles -> out_valid=1, out_data=8'h5C held, and in_ready=0 for all 3 cycles; then out_ready=1 -> drained, next beat loaded without a bubble.
REQ-031 ptr=3 with in_valid=4'b0101 -> ch0 granted first, then ch2, then ch0 (wrap-around).
REQ-032 Reset pulsed asynchronously mid-cycle while out_valid=1 -> out_valid drops immediately, and after release ch0 has priority.
REQ-033 With STREAM_MUX_LOCK_EN: ch1 sends a 3-beat packet (in_last on beat 3) while ch0 and ch3 are valid -> beats 1..3 all have out_ch=1 and out_last=1 only on beat 3, then ch3 is granted next.
REQ-034 Random in_valid and out_ready over 10k cycles -> per-channel beat order is preserved, no beats are lost or duplicated, and in_ready is always one-hot or zero.
